// File: rtl/evm_ballot_ctrl.sv
// EVM presiding-officer ballot control: debounced buttons, one ballot per voter, vote strobe.
// Optional ARMED-state timeout is built only when EVM_TIMEOUT_EN is defined.
module evm_ballot_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
    parameter int unsigned MAX_BALLOTS     = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ballot_btn,
    input  logic       close_btn,
    input  logic       cast_btn,
    input  logic [2:0] voter_switch,
    output logic       voting_en,
    output logic       vote_valid,
    output logic [2:0] vote_sel,
    output logic       invalid,
    output logic       busy_led,
    output logic       closed,
    output logic       full,
    output logic       timeout,
    output logic [6:0] ballots_issued
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0] MAX7 = 7'(MAX_BALLOTS);

    if (DEBOUNCE_CYCLES < 2 || MAX_BALLOTS > 127 || MAX_BALLOTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("evm_ballot_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ARMED, CAST, CLOSED} state_t;
    state_t state;

    // Bit order in all button vectors: 0 = BALLOT, 1 = CLOSE, 2 = CAST.
    logic [2:0]    raw, sync1, sync2, level, level_q, press;
    logic [DW-1:0] cnt [3];
    logic          bal_p, cls_p, cst_p, switch_ok;

    assign raw       = {cast_btn, close_btn, ballot_btn};
    assign bal_p     = press[0];
    assign cls_p     = press[1];
    assign cst_p     = press[2];
    assign switch_ok = voter_switch inside {3'b001, 3'b010, 3'b100};
    assign busy_led  = voting_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            press   <= '0;
            for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            // Level flips on the sample after DEBOUNCE_CYCLES consecutive differing samples.
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef EVM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            voting_en      <= 1'b0;
            vote_valid     <= 1'b0;
            vote_sel       <= '0;
            invalid        <= 1'b0;
            closed         <= 1'b0;
            full           <= 1'b0;
            ballots_issued <= '0;
`ifdef EVM_TIMEOUT_EN
            timeout        <= 1'b0;
            tcnt           <= '0;
`endif
        end else begin
            vote_valid <= 1'b0;
            vote_sel   <= '0;
            invalid    <= 1'b0;
`ifdef EVM_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cls_p) begin
                        state  <= CLOSED;
                        closed <= 1'b1;
                    end else if (bal_p && !full) begin
                        state     <= ARMED;
                        voting_en <= 1'b1;
`ifdef EVM_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end
                end
                ARMED: begin
                    // A cast press in the expiry cycle takes priority over the timeout.
                    if (cst_p && switch_ok) begin
                        state      <= CAST;
                        voting_en  <= 1'b0;
                        vote_valid <= 1'b1;
                        vote_sel   <= voter_switch;
                    end else if (cst_p) begin
                        invalid <= 1'b1;
`ifdef EVM_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end
`ifdef EVM_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        voting_en <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                CAST: begin
                    state <= IDLE;
                    if (ballots_issued < MAX7) begin
                        ballots_issued <= ballots_issued + 7'd1;
                        full           <= (ballots_issued + 7'd1 == MAX7);
                    end
                end
                CLOSED: begin
                    voting_en <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed self-checking bench for evm_ballot_ctrl (DEBOUNCE=4, TIMEOUT=20, MAX=3).
module tb_evm_ballot_ctrl;
    localparam int D = 4;
    localparam int T = 20;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst, ballot_btn, close_btn, cast_btn;
    logic [2:0] voter_switch;
    logic       voting_en, vote_valid, invalid, busy_led, closed, full, timeout;
    logic [2:0] vote_sel;
    logic [6:0] ballots_issued;

    int vectors = 0;
    int errors  = 0;

    int         n_valid = 0, n_invalid = 0, n_timeout = 0, n_arm = 0;
    logic [2:0] last_sel = '0;
    logic       en_d = 1'b0;

    evm_ballot_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .MAX_BALLOTS    (M)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ballot_btn    (ballot_btn),
        .close_btn     (close_btn),
        .cast_btn      (cast_btn),
        .voter_switch  (voter_switch),
        .voting_en     (voting_en),
        .vote_valid    (vote_valid),
        .vote_sel      (vote_sel),
        .invalid       (invalid),
        .busy_led      (busy_led),
        .closed        (closed),
        .full          (full),
        .timeout       (timeout),
        .ballots_issued(ballots_issued)
    );

    always #5 clk = ~clk;

    // Pulse/event tallies sampled on the falling edge.
    always @(negedge clk) begin
        if (vote_valid) begin
            n_valid++;
            last_sel = vote_sel;
        end
        if (invalid) n_invalid++;
        if (timeout) n_timeout++;
        if (voting_en && !en_d) n_arm++;
        en_d = voting_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // btn: 0 = BALLOT, 1 = CLOSE, 2 = CAST, 3 = CLOSE+BALLOT together
    task automatic press(input int btn, input int hold, input int after);
        @(negedge clk);
        if (btn == 0 || btn == 3) ballot_btn = 1'b1;
        if (btn == 1 || btn == 3) close_btn  = 1'b1;
        if (btn == 2)             cast_btn   = 1'b1;
        cycles(hold);
        ballot_btn = 1'b0;
        close_btn  = 1'b0;
        cast_btn   = 1'b0;
        cycles(after);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if ({voting_en, vote_valid, vote_sel, invalid, busy_led, closed, full, timeout} !== 10'b0) begin
            errors++;
            $display("FAIL %s outputs: got en=%b vv=%b sel=%b inv=%b busy=%b cl=%b full=%b to=%b, want all 0",
                     tag, voting_en, vote_valid, vote_sel, invalid, busy_led, closed, full, timeout);
        end
        vectors++;
        if (ballots_issued !== 7'd0) begin
            errors++;
            $display("FAIL %s count: got %0d want 0", tag, ballots_issued);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_outputs("reset");
    endtask

    task automatic test_valid_vote();
        int v0;
        do_reset();
        v0 = n_valid;
        press(0, D + 5, 2);
        vectors++;
        if (voting_en !== 1'b1 || busy_led !== 1'b1) begin
            errors++;
            $display("FAIL valid_arm: got en=%b busy=%b want 1/1", voting_en, busy_led);
        end
        voter_switch = 3'b010;
        press(2, D + 5, D + 5);
        vectors++;
        if (voting_en !== 1'b0) begin
            errors++;
            $display("FAIL valid_en_drop: got %b want 0", voting_en);
        end
        vectors++;
        if (n_valid - v0 !== 1) begin
            errors++;
            $display("FAIL valid_strobes: got %0d want 1", n_valid - v0);
        end
        vectors++;
        if (last_sel !== 3'b010) begin
            errors++;
            $display("FAIL valid_sel: got %b want 010", last_sel);
        end
        vectors++;
        if (ballots_issued !== 7'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL valid_count: got %0d full=%b want 1 full=0", ballots_issued, full);
        end
        vectors++;
        if (vote_sel !== 3'b000) begin
            errors++;
            $display("FAIL valid_sel_idle: got %b want 000", vote_sel);
        end
    endtask

    task automatic test_invalid_then_valid();
        int v0, i0;
        do_reset();
        v0 = n_valid;
        i0 = n_invalid;
        press(0, D + 5, 2);
        voter_switch = 3'b011;
        press(2, D + 5, D + 5);
        vectors++;
        if (n_invalid - i0 !== 1) begin
            errors++;
            $display("FAIL inv_pulse: got %0d want 1", n_invalid - i0);
        end
        vectors++;
        if (voting_en !== 1'b1 || n_valid - v0 !== 0 || ballots_issued !== 7'd0) begin
            errors++;
            $display("FAIL inv_state: got en=%b votes=%0d count=%0d want 1/0/0",
                     voting_en, n_valid - v0, ballots_issued);
        end
        voter_switch = 3'b100;
        press(2, D + 5, 2);
        voter_switch = 3'b001;  // switch change after latch must not alter the strobe
        cycles(D + 5);
        vectors++;
        if (n_valid - v0 !== 1 || last_sel !== 3'b100) begin
            errors++;
            $display("FAIL inv_then_valid: got votes=%0d sel=%b want 1/100", n_valid - v0, last_sel);
        end
        vectors++;
        if (ballots_issued !== 7'd1 || voting_en !== 1'b0) begin
            errors++;
            $display("FAIL inv_then_count: got count=%0d en=%b want 1/0", ballots_issued, voting_en);
        end
    endtask

    task automatic test_bounce_and_hold();
        int v0, i0, a0;
        do_reset();
        v0 = n_valid;
        i0 = n_invalid;
        press(0, D + 5, 2);
        voter_switch = 3'b001;
        for (int k = 0; k < 5; k++) begin
            cast_btn = 1'b1;
            cycles(2);
            cast_btn = 1'b0;
            cycles(2);
        end
        cycles(10);
        vectors++;
        if (n_valid - v0 !== 0 || n_invalid - i0 !== 0) begin
            errors++;
            $display("FAIL bounce: got votes=%0d invalid=%0d want 0/0", n_valid - v0, n_invalid - i0);
        end
`ifndef EVM_TIMEOUT_EN
        vectors++;
        if (voting_en !== 1'b1) begin
            errors++;
            $display("FAIL bounce_armed: got en=%b want 1", voting_en);
        end
`endif
        do_reset();
        a0 = n_arm;
        press(0, 100, 10);
        vectors++;
        if (n_arm - a0 !== 1) begin
            errors++;
            $display("FAIL hold_arm: got %0d ARMED entries want 1", n_arm - a0);
        end
`ifndef EVM_TIMEOUT_EN
        vectors++;
        if (voting_en !== 1'b1) begin
            errors++;
            $display("FAIL hold_en: got %b want 1", voting_en);
        end
`endif
    endtask

    task automatic test_full();
        int v0, a0;
        logic [2:0] sels [3] = '{3'b001, 3'b010, 3'b100};
        do_reset();
        v0 = n_valid;
        for (int k = 0; k < 3; k++) begin
            press(0, D + 5, 2);
            voter_switch = sels[k];
            press(2, D + 5, D + 5);
            vectors++;
            if (ballots_issued !== 7'(k + 1) || last_sel !== sels[k]) begin
                errors++;
                $display("FAIL full_vote%0d: got count=%0d sel=%b want %0d/%b",
                         k, ballots_issued, last_sel, k + 1, sels[k]);
            end
            vectors++;
            if (full !== (k == 2)) begin
                errors++;
                $display("FAIL full_flag%0d: got %b want %b", k, full, (k == 2));
            end
        end
        a0 = n_arm;
        press(0, D + 5, D + 5);
        vectors++;
        if (voting_en !== 1'b0 || n_arm - a0 !== 0) begin
            errors++;
            $display("FAIL full_block: got en=%b arms=%0d want 0/0", voting_en, n_arm - a0);
        end
        vectors++;
        if (ballots_issued !== 7'd3 || n_valid - v0 !== 3) begin
            errors++;
            $display("FAIL full_count: got count=%0d votes=%0d want 3/3", ballots_issued, n_valid - v0);
        end
    endtask

    task automatic test_close();
        int v0, a0;
        do_reset();
        v0 = n_valid;
        a0 = n_arm;
        press(3, D + 5, D + 5);
        vectors++;
        if (closed !== 1'b1 || voting_en !== 1'b0 || n_arm - a0 !== 0) begin
            errors++;
            $display("FAIL close_wins: got closed=%b en=%b arms=%0d want 1/0/0", closed, voting_en, n_arm - a0);
        end
        press(0, D + 5, 2);
        voter_switch = 3'b001;
        press(2, D + 5, D + 5);
        press(1, D + 5, D + 5);
        vectors++;
        if (voting_en !== 1'b0 || n_valid - v0 !== 0 || n_arm - a0 !== 0) begin
            errors++;
            $display("FAIL close_lock: got en=%b votes=%0d arms=%0d want 0/0/0", voting_en, n_valid - v0, n_arm - a0);
        end
        vectors++;
        if (closed !== 1'b1 || ballots_issued !== 7'd0) begin
            errors++;
            $display("FAIL close_hold: got closed=%b count=%0d want 1/0", closed, ballots_issued);
        end
        do_reset();
        check_idle_outputs("close_reset");
    endtask

    task automatic test_reset_mid_ballot();
        int v0;
        do_reset();
        press(0, D + 5, 2);
        voter_switch = 3'b010;
        press(2, D + 5, D + 5);
        press(0, D + 5, 2);
        v0 = n_valid;
        do_reset();
        cycles(5);
        vectors++;
        if (n_valid - v0 !== 0) begin
            errors++;
            $display("FAIL midreset_vote: got %0d votes want 0", n_valid - v0);
        end
        check_idle_outputs("midreset");
    endtask

    task automatic test_timeout();
        int t0, v0;
        do_reset();
        t0 = n_timeout;
        v0 = n_valid;
`ifdef EVM_TIMEOUT_EN
        press(0, D + 5, 2);
        cycles(T + 5);
        vectors++;
        if (n_timeout - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d want 1", n_timeout - t0);
        end
        vectors++;
        if (voting_en !== 1'b0 || ballots_issued !== 7'd0 || n_valid - v0 !== 0) begin
            errors++;
            $display("FAIL timeout_state: got en=%b count=%0d votes=%0d want 0/0/0",
                     voting_en, ballots_issued, n_valid - v0);
        end
        press(0, D + 5, 2);
        vectors++;
        if (voting_en !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rearm: got en=%b want 1", voting_en);
        end
`else
        press(0, D + 5, 2);
        cycles(1000);
        vectors++;
        if (voting_en !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_en: got %b want 1", voting_en);
        end
        vectors++;
        if (n_timeout - t0 !== 0 || n_valid - v0 !== 0) begin
            errors++;
            $display("FAIL no_timeout_pulse: got timeouts=%0d votes=%0d want 0/0", n_timeout - t0, n_valid - v0);
        end
`endif
    endtask

    initial begin
        rst          = 1'b1;
        ballot_btn   = 1'b0;
        close_btn    = 1'b0;
        cast_btn     = 1'b0;
        voter_switch = 3'b000;
        test_reset();
        test_valid_vote();
        test_invalid_then_valid();
        test_bounce_and_hold();
        test_full();
        test_close();
        test_reset_mid_ballot();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
